// File: rtl/pcint_grp_ctrl.sv
// ---------------------------------------------------------------------------
// pcint_grp_ctrl
//   Pin-change interrupt controller for one PCINT group.
//   Synchronises the group's pad inputs and detects changes on the pins that
//   are enabled in PCMSKn. It owns PCMSKn, bit GRP_BIT of PCICR (PCIEn) and
//   bit GRP_BIT of PCIFR (PCIFn), and it raises the group interrupt request.
//
// Ports
//   cp2       in   system clock, rising edge
//   ireset    in   synchronous active-high reset
//   IO_Addr   in   I/O-space address (PCIFR)
//   iore/iowe in   I/O read / write strobes
//   ramadr    in   data-space address (PCICR, PCMSKn)
//   ramre/ramwe in extended read / write strobes
//   dbus_in   in   write data
//   dbus_out  out  read data; PCICR/PCIFR reads drive only bit GRP_BIT
//   out_en    out  high while an owned register is being read
//   pin_i     in   raw asynchronous pad inputs
//   irq_ack   in   vector-taken pulse, clears PCIFn
//   irq_o     out  PCIFn & PCIEn
//   pcmsk_o   out  PCMSKn value
//   pcie_o    out  PCIEn value
//   wake_o    out  asynchronous wake request
//
// Configuration macro
//   PCINT_ASYNC_WAKE_EN : when defined, wake_o is a combinational compare of
//   the raw pins against the last sampled value, gated by PCIEn and PCMSKn.
//   When undefined, wake_o is tied low.
// ---------------------------------------------------------------------------
module pcint_grp_ctrl #(
    parameter int         WIDTH     = 4,
    parameter int         GRP_BIT   = 3,
    parameter logic [7:0] PCMSK_ADR = 8'h73,
    parameter logic [7:0] PCICR_ADR = 8'h68,
    parameter logic [5:0] PCIFR_ADR = 6'h1B
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic [5:0]       IO_Addr,
    input  logic             iore,
    input  logic             iowe,
    input  logic [7:0]       ramadr,
    input  logic             ramre,
    input  logic             ramwe,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             out_en,
    input  logic [WIDTH-1:0] pin_i,
    input  logic             irq_ack,
    output logic             irq_o,
    output logic [WIDTH-1:0] pcmsk_o,
    output logic             pcie_o,
    output logic             wake_o
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [1:0]       settle_reg;
    logic [WIDTH-1:0] pcmsk_reg;
    logic             pcie_reg;
    logic             pcif_reg;
    logic             pcif_next;

    logic [WIDTH-1:0] chg;
    logic             chg_hit;
    logic             pcifr_wr;
    logic             pcicr_wr;
    logic             pcmsk_wr;
    logic             pcifr_rd;
    logic             pcicr_rd;
    logic             pcmsk_rd;
    logic             flag_clr;
    logic [7:0]       pcmsk_ext;
    logic             unused_dbus;

    // Only bit GRP_BIT and the low WIDTH bits of the write data are consumed.
    assign unused_dbus = ^dbus_in;

    assign pcifr_wr = iowe  & (IO_Addr == PCIFR_ADR);
    assign pcifr_rd = iore  & (IO_Addr == PCIFR_ADR);
    assign pcicr_wr = ramwe & (ramadr == PCICR_ADR);
    assign pcicr_rd = ramre & (ramadr == PCICR_ADR);
    assign pcmsk_wr = ramwe & (ramadr == PCMSK_ADR);
    assign pcmsk_rd = ramre & (ramadr == PCMSK_ADR);

    // Change detection only counts once the settle window after reset is over,
    // so pins that are already high when reset releases never raise a flag.
    assign chg     = (s2_reg ^ prev_reg) & pcmsk_reg;
    assign chg_hit = (|chg) & (settle_reg == 2'd0);

    assign flag_clr = (pcifr_wr & dbus_in[GRP_BIT]) | irq_ack;

    // A set in the same cycle as a clear wins, so no pin change is lost.
    always_comb begin
        pcif_next = pcif_reg;
        if (chg_hit) begin
            pcif_next = 1'b1;
        end else if (flag_clr) begin
            pcif_next = 1'b0;
        end
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            s1_reg     <= '0;
            s2_reg     <= '0;
            prev_reg   <= '0;
            settle_reg <= 2'd3;
            pcmsk_reg  <= '0;
            pcie_reg   <= 1'b0;
            pcif_reg   <= 1'b0;
        end else begin
            s1_reg   <= pin_i;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
            if (settle_reg != 2'd0) begin
                settle_reg <= settle_reg - 2'd1;
            end
            if (pcmsk_wr) begin
                pcmsk_reg <= dbus_in[WIDTH-1:0];
            end
            if (pcicr_wr) begin
                pcie_reg <= dbus_in[GRP_BIT];
            end
            pcif_reg <= pcif_next;
        end
    end

    // Zero-extend the mask to the bus width; unimplemented bits read as 0.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_msk_ext
            if (gi < WIDTH) begin : g_bit
                assign pcmsk_ext[gi] = pcmsk_reg[gi];
            end else begin : g_zero
                assign pcmsk_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Shared PCICR/PCIFR reads drive only this group's bit; the top level ORs
    // the groups together.
    always_comb begin
        dbus_out = 8'h00;
        out_en   = 1'b0;
        if (pcifr_rd) begin
            dbus_out[GRP_BIT] = pcif_reg;
            out_en            = 1'b1;
        end
        if (pcicr_rd) begin
            dbus_out[GRP_BIT] = dbus_out[GRP_BIT] | pcie_reg;
            out_en            = 1'b1;
        end
        if (pcmsk_rd) begin
            dbus_out = dbus_out | pcmsk_ext;
            out_en   = 1'b1;
        end
    end

    assign irq_o   = pcif_reg & pcie_reg;
    assign pcmsk_o = pcmsk_reg;
    assign pcie_o  = pcie_reg;

`ifdef PCINT_ASYNC_WAKE_EN
    // Raw pins against the last sampled value: works with cp2 gated in sleep.
    assign wake_o = pcie_reg & (|((pin_i ^ prev_reg) & pcmsk_reg));
`else
    assign wake_o = 1'b0;
`endif

endmodule

// File: tb/tb_pcint_grp_ctrl.sv
module tb_pcint_grp_ctrl;

    localparam logic [7:0] PCMSK_ADR = 8'h73;
    localparam logic [7:0] PCICR_ADR = 8'h68;
    localparam logic [5:0] PCIFR_ADR = 6'h1B;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [3:0] pin_i;
    logic       irq_ack;
    logic       irq_o;
    logic [3:0] pcmsk_o;
    logic       pcie_o;
    logic       wake_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rd_data;
    logic       rd_oe;

    pcint_grp_ctrl #(
        .WIDTH    (4),
        .GRP_BIT  (3),
        .PCMSK_ADR(PCMSK_ADR),
        .PCICR_ADR(PCICR_ADR),
        .PCIFR_ADR(PCIFR_ADR)
    ) dut (
        .cp2     (cp2),
        .ireset  (ireset),
        .IO_Addr (IO_Addr),
        .iore    (iore),
        .iowe    (iowe),
        .ramadr  (ramadr),
        .ramre   (ramre),
        .ramwe   (ramwe),
        .dbus_in (dbus_in),
        .dbus_out(dbus_out),
        .out_en  (out_en),
        .pin_i   (pin_i),
        .irq_ack (irq_ack),
        .irq_o   (irq_o),
        .pcmsk_o (pcmsk_o),
        .pcie_o  (pcie_o),
        .wake_o  (wake_o)
    );

    always #5 cp2 = ~cp2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %-16s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %-16s %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge cp2);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ram_wr(input logic [7:0] adr, input logic [7:0] d);
        ramadr  = adr;
        dbus_in = d;
        ramwe   = 1'b1;
        step();
        ramwe   = 1'b0;
    endtask

    task automatic io_wr(input logic [5:0] adr, input logic [7:0] d);
        IO_Addr = adr;
        dbus_in = d;
        iowe    = 1'b1;
        step();
        iowe    = 1'b0;
    endtask

    task automatic ram_rd(input logic [7:0] adr, output logic [7:0] d, output logic oe);
        ramadr = adr;
        ramre  = 1'b1;
        #1;
        d      = dbus_out;
        oe     = out_en;
        ramre  = 1'b0;
    endtask

    task automatic io_rd(input logic [5:0] adr, output logic [7:0] d, output logic oe);
        IO_Addr = adr;
        iore    = 1'b1;
        #1;
        d       = dbus_out;
        oe      = out_en;
        iore    = 1'b0;
    endtask

    task automatic do_reset();
        ireset = 1'b1;
        steps(2);
        ireset = 1'b0;
    endtask

    initial begin
        ireset  = 1'b0;
        IO_Addr = 6'h00;
        iore    = 1'b0;
        iowe    = 1'b0;
        ramadr  = 8'h00;
        ramre   = 1'b0;
        ramwe   = 1'b0;
        dbus_in = 8'h00;
        irq_ack = 1'b0;
        pin_i   = 4'hF;

        // 1: reset with all pins high, mask written immediately after release
        ireset = 1'b1;
        steps(2);
        check("rst_irq", irq_o, 0);
        check("rst_pcmsk", pcmsk_o, 4'h0);
        check("rst_pcie", pcie_o, 0);
        check("rst_wake", wake_o, 0);
        check("rst_out_en", out_en, 0);
        check("rst_dbus", dbus_out, 8'h00);
        ireset = 1'b0;
        ram_wr(PCMSK_ADR, 8'h0F);
        ram_wr(PCICR_ADR, 8'h08);
        steps(10);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("settle_pcifr", rd_data, 8'h00);
        check("settle_irq", irq_o, 0);

        // 2: latency of a masked rising edge on pin 2
        pin_i = 4'h0;
        do_reset();
        ram_wr(PCMSK_ADR, 8'h04);
        ram_wr(PCICR_ADR, 8'h08);
        steps(4);
        pin_i[2] = 1'b1;
        step();
        check("lat_k", irq_o, 0);
        step();
        check("lat_k1", irq_o, 0);
        step();
        check("lat_k2", irq_o, 1);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("pcifr_rd", rd_data, 8'h08);
        check("pcifr_oe", rd_oe, 1);
        io_rd(6'h1A, rd_data, rd_oe);
        check("other_io_oe", rd_oe, 0);

        // 3: flag clear only with a 1 in bit GRP_BIT
        io_wr(PCIFR_ADR, 8'h00);
        check("clr0_irq", irq_o, 1);
        io_wr(6'h1A, 8'hFF);
        check("clr_badadr", irq_o, 1);
        io_wr(PCIFR_ADR, 8'h08);
        check("clr1_irq", irq_o, 0);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("clr1_pcifr", rd_data, 8'h00);

        // 4: unmasked pin toggles are never recorded
        for (int i = 0; i < 6; i++) begin
            pin_i[1] = ~pin_i[1];
            steps(2);
        end
        steps(3);
        check("unmask_irq", irq_o, 0);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("unmask_pcifr", rd_data, 8'h00);
        ram_rd(PCMSK_ADR, rd_data, rd_oe);
        check("pcmsk_rd", rd_data, 8'h04);
        check("pcmsk_oe", rd_oe, 1);
        ram_rd(PCICR_ADR, rd_data, rd_oe);
        check("pcicr_rd", rd_data, 8'h08);
        check("pcmsk_o", pcmsk_o, 4'h4);
        check("pcie_o", pcie_o, 1);

        // 5: set wins over a same-cycle clear (write, then irq_ack)
        pin_i[2] = 1'b0;
        steps(2);
        io_wr(PCIFR_ADR, 8'h08);
        check("set_vs_wr", irq_o, 1);
        step();
        check("set_vs_wr_hold", irq_o, 1);
        io_wr(PCIFR_ADR, 8'h08);
        check("clr_after", irq_o, 0);
        pin_i[2] = 1'b1;
        steps(2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("set_vs_ack", irq_o, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ack_clr", irq_o, 0);

        // 6: flag sets with PCIE=0, irq follows PCIE
        ram_wr(PCICR_ADR, 8'h00);
        pin_i[2] = 1'b0;
        steps(3);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("noie_pcifr", rd_data, 8'h08);
        check("noie_irq", irq_o, 0);
        ram_wr(PCICR_ADR, 8'h08);
        check("ie_irq", irq_o, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ie_ack", irq_o, 0);

        // Enabling a mask bit later does not replay a past edge on pin 0
        pin_i[0] = 1'b1;
        steps(4);
        ram_wr(PCMSK_ADR, 8'h05);
        steps(3);
        io_rd(PCIFR_ADR, rd_data, rd_oe);
        check("no_replay", rd_data, 8'h00);

        // Register boundaries: upper mask bits and non-owned PCICR bits
        ram_wr(PCMSK_ADR, 8'hFF);
        ram_rd(PCMSK_ADR, rd_data, rd_oe);
        check("pcmsk_ff_rd", rd_data, 8'h0F);
        ram_wr(PCICR_ADR, 8'hF7);
        check("pcicr_f7", pcie_o, 0);
        ram_rd(PCICR_ADR, rd_data, rd_oe);
        check("pcicr_f7_rd", rd_data, 8'h00);
        steps(3);
        check("stable_irq", irq_o, 0);

        // Wake request straight from the raw pins
        ram_wr(PCICR_ADR, 8'h08);
        pin_i[3] = ~pin_i[3];
        #1;
`ifdef PCINT_ASYNC_WAKE_EN
        check("wake_async", wake_o, 1);
`else
        check("wake_off", wake_o, 0);
`endif
        steps(3);
        check("wake_flag", irq_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
